// File: rtl/counter_driver_pkg.sv
// Shared types and default widths for the counter increment driver.
package counter_driver_pkg;

  // Default widths; the driver exposes each as an overridable parameter.
  localparam int COUNT_W_DEFAULT = 48;  // counter's full count output width
  localparam int CNT_W_DEFAULT   = 16;  // live counter width, delta wraps here
  localparam int N_W_DEFAULT     = 16;  // pulse-count command width
  localparam int GAP_W_DEFAULT   = 8;   // inter-pulse gap command width

  // Burst sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,  // waiting for a command
    ST_PULSE  = 3'd1,  // incr_out high this cycle
    ST_GAP    = 3'd2,  // idle cycles between pulses
    ST_SETTLE = 3'd3,  // counter absorbs the last pulse, result captured
    ST_DONE   = 3'd4   // result offered on the result channel
  } state_t;

endpackage : counter_driver_pkg

// File: rtl/counter_driver.sv
// Initiator for a counter's increment port: takes a (count, gap) command,
// emits that many one-cycle increment pulses separated by the gap, and
// reports the counter value before and after the burst together with the
// wrapped delta and whether it equals the requested pulse count.
module counter_driver
  import counter_driver_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int N_W     = N_W_DEFAULT,
  parameter int GAP_W   = GAP_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  // command channel
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [N_W-1:0]     cmd_n,
  input  logic [GAP_W-1:0]   cmd_gap,
  // counter interface
  output logic               incr_out,
  input  logic [COUNT_W-1:0] count_in,
  // result channel
  output logic               res_valid,
  input  logic               res_ready,
  output logic [COUNT_W-1:0] res_start,
  output logic [COUNT_W-1:0] res_end,
  output logic [CNT_W-1:0]   res_delta,
  output logic               res_match
);

  state_t             state;
  logic [N_W-1:0]     n_lat;      // requested pulse count, kept for the compare
  logic [N_W-1:0]     remaining;  // pulses still to issue, including the current one
  logic [GAP_W-1:0]   gap_lat;    // requested gap length
  logic [GAP_W-1:0]   gap_timer;  // gap cycles left, including the current one

  // Wrapped distance travelled by the live counter bits since accept.
  logic [CNT_W-1:0]   settle_delta;
  logic               settle_match;

  // Delta and match computed on the SETTLE-cycle count value.
  assign settle_delta = count_in[CNT_W-1:0] - res_start[CNT_W-1:0];
  assign settle_match = (settle_delta == n_lat[CNT_W-1:0]);

  // Burst sequencer with registered handshake and pulse outputs.
  // NOTE: every output is assigned alongside the state it belongs to with
  // non-blocking assignments, so all of them are flops (no input-to-output
  // path, no glitches on incr_out) and read the pre-edge values of the
  // state within this block. Reset clears them asynchronously, so incr_out
  // drops the moment rst rises and cmd_ready only rises on the first edge
  // after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b0;
      incr_out  <= 1'b0;
      res_valid <= 1'b0;
      res_start <= '0;
      res_end   <= '0;
      res_delta <= '0;
      res_match <= 1'b0;
      n_lat     <= '0;
      remaining <= '0;
      gap_lat   <= '0;
      gap_timer <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            n_lat     <= cmd_n;
            remaining <= cmd_n;
            gap_lat   <= cmd_gap;
            res_start <= count_in;
            cmd_ready <= 1'b0;
            if (cmd_n != '0) begin
              state    <= ST_PULSE;
              incr_out <= 1'b1;
            end else begin
              state    <= ST_SETTLE;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        ST_PULSE: begin
          remaining <= remaining - N_W'(1);
          if (remaining == N_W'(1)) begin
            state    <= ST_SETTLE;
            incr_out <= 1'b0;
          end else if (gap_lat == '0) begin
            state    <= ST_PULSE;
            incr_out <= 1'b1;
          end else begin
            state     <= ST_GAP;
            gap_timer <= gap_lat;
            incr_out  <= 1'b0;
          end
        end

        ST_GAP: begin
          if (gap_timer == GAP_W'(1)) begin
            state     <= ST_PULSE;
            gap_timer <= '0;
            incr_out  <= 1'b1;
          end else begin
            gap_timer <= gap_timer - GAP_W'(1);
          end
        end

        ST_SETTLE: begin
          res_end   <= count_in;
          res_delta <= settle_delta;
          res_match <= settle_match;
          res_valid <= 1'b1;
          state     <= ST_DONE;
        end

        ST_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b0;
          incr_out  <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : counter_driver

// File: tb/tb_counter_driver.sv
// Directed bench for counter_driver with a small 16-bit counter model
// (sync reset, preset, increment) standing in for the real counter.
module tb_counter_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_n = '0;
  logic [7:0]  cmd_gap = '0;
  logic        incr_out;
  logic [47:0] count_in;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [47:0] res_start;
  logic [47:0] res_end;
  logic [15:0] res_delta;
  logic        res_match;

  // Counter model controls
  logic        cnt_rst = 1'b1;
  logic        preset_en = 1'b0;
  logic [15:0] preset_val = '0;
  logic [15:0] cnt_q = '0;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  always #5 clk = ~clk;

  // Stand-in counter: reset, preset, then increment on incr_out.
  always_ff @(posedge clk) begin
    if (cnt_rst)        cnt_q <= '0;
    else if (preset_en) cnt_q <= preset_val;
    else if (incr_out)  cnt_q <= cnt_q + 16'd1;
  end

  assign count_in = {32'h0, cnt_q};

  counter_driver dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_n     (cmd_n),
    .cmd_gap   (cmd_gap),
    .incr_out  (incr_out),
    .count_in  (count_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_start (res_start),
    .res_end   (res_end),
    .res_delta (res_delta),
    .res_match (res_match)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Load the counter model; called at a negedge, returns at the next one.
  task automatic preset(input logic [15:0] v);
    preset_en  = 1'b1;
    preset_val = v;
    @(negedge clk);
    preset_en  = 1'b0;
  endtask

  // Issue a command from IDLE and follow it cycle by cycle to res_valid.
  // Pulses are expected at cycles 1+k*(g+1), k<n; res_valid at cycle lat.
  task automatic run_cmd(input string tag, input int n, input int g,
                         input logic [47:0] e_start, input logic [47:0] e_end,
                         input logic [15:0] e_delta, input logic e_match);
    int   lat;
    logic exp_pulse;
    lat = (n == 0) ? 2 : 3 + (n - 1) * (g + 1);
    check({tag, ".cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_n     = n[15:0];
    cmd_gap   = g[7:0];
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == 1) cmd_valid = 1'b0;
      exp_pulse = (c < lat - 1) && (((c - 1) % (g + 1)) == 0);
      check($sformatf("%s.incr_c%0d", tag, c), incr_out, exp_pulse);
      check($sformatf("%s.rv_c%0d", tag, c), res_valid, (c == lat));
    end
    check({tag, ".start"}, res_start, e_start);
    check({tag, ".end"},   res_end,   e_end);
    check({tag, ".delta"}, res_delta, e_delta);
    check({tag, ".match"}, res_match, e_match);
    check({tag, ".busy"},  cmd_ready, 0);
  endtask

  // Consume the result; driver must be back in IDLE a cycle later.
  task automatic ack(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, ".ack_rv"},    res_valid, 0);
    check({tag, ".ack_ready"}, cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: asynchronous reset mid-cycle
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst.incr",  incr_out,  0);
    check("rst.rv",    res_valid, 0);
    check("rst.ready", cmd_ready, 0);
    check("rst.start", res_start, 0);
    check("rst.end",   res_end,   0);
    check("rst.delta", res_delta, 0);
    check("rst.match", res_match, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rel.ready", cmd_ready, 1);
    check("rel.incr",  incr_out,  0);
    check("rel.rv",    res_valid, 0);
    cnt_rst = 1'b0;

    // 2: counter at 5, N=3 G=0
    preset(16'd5);
    run_cmd("n3g0", 3, 0, 48'd5, 48'd8, 16'd3, 1'b1);
    ack("n3g0");

    // 3: counter at 0, N=2 G=2, then N=0
    preset(16'd0);
    run_cmd("n2g2", 2, 2, 48'd0, 48'd2, 16'd2, 1'b1);
    ack("n2g2");
    run_cmd("n0", 0, 0, 48'd2, 48'd2, 16'd0, 1'b1);
    ack("n0");

    // 4: wrap-around through 0xFFFF
    preset(16'hFFFE);
    run_cmd("wrap", 4, 1, 48'h0000_0000_FFFE, 48'h0000_0000_0002, 16'd4, 1'b1);
    ack("wrap");

    // 5: counter held in reset, pulses have no effect
    cnt_rst = 1'b1;
    @(negedge clk);
    run_cmd("cntrst", 5, 0, 48'd0, 48'd0, 16'd0, 1'b0);
    ack("cntrst");
    cnt_rst = 1'b0;

    // 6a: result held with res_ready low while a new command is offered
    preset(16'h0100);
    run_cmd("hold", 1, 0, 48'h100, 48'h101, 16'd1, 1'b1);
    cmd_valid = 1'b1;
    cmd_n     = 16'd3;
    cmd_gap   = 8'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("hold.rv_%0d", i),    res_valid, 1);
      check($sformatf("hold.ready_%0d", i), cmd_ready, 0);
      check($sformatf("hold.incr_%0d", i),  incr_out,  0);
      check($sformatf("hold.end_%0d", i),   res_end,   48'h101);
      check($sformatf("hold.delta_%0d", i), res_delta, 16'd1);
    end
    cmd_valid = 1'b0;
    ack("hold");

    // 6b: reset during the second pulse of N=4 G=1
    preset(16'd0);
    cmd_valid = 1'b1;
    cmd_n     = 16'd4;
    cmd_gap   = 8'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid.p1", incr_out, 1);
    @(negedge clk);
    check("mid.gap", incr_out, 0);
    @(negedge clk);
    check("mid.p2", incr_out, 1);
    #1 rst = 1'b1;
    #1;
    check("mid.rst_incr",  incr_out,  0);
    check("mid.rst_rv",    res_valid, 0);
    check("mid.rst_ready", cmd_ready, 0);
    check("mid.rst_end",   res_end,   0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid.rel_ready", cmd_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("mid.idle_incr_%0d", i), incr_out,  0);
      check($sformatf("mid.idle_rv_%0d", i),   res_valid, 0);
    end

    // Only the first pulse reached the counter; a fresh burst still works.
    run_cmd("post", 2, 0, 48'd1, 48'd3, 16'd2, 1'b1);
    ack("post");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_counter_driver
